// File: rtl/player_input_conditioner_if.sv
// Button/key bundle between the raw push-button pins and the input conditioner.
// master drives the raw active-low buttons and observes the conditioned outputs;
// slave is the conditioner itself.
interface player_input_conditioner_if;
  logic [3:0] btn_1_n;
  logic [3:0] btn_2_n;
  logic       btn_start_n;
  logic [3:0] keys_1;
  logic [3:0] keys_2;
  logic       pause;
  logic       start_pulse;

  modport master (
    output btn_1_n,
    output btn_2_n,
    output btn_start_n,
    input  keys_1,
    input  keys_2,
    input  pause,
    input  start_pulse
  );

  modport slave (
    input  btn_1_n,
    input  btn_2_n,
    input  btn_start_n,
    output keys_1,
    output keys_2,
    output pause,
    output start_pulse
  );
endinterface

// File: rtl/player_input_conditioner.sv
// Player input conditioner: synchronises and debounces the 2x4 direction buttons
// and the start button, then presents clean one-hot key vectors plus a start
// pulse and a pause level that toggles on every accepted start press.
module player_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic                        CLOCK_25,
  input  logic                        RESET_N,
  player_input_conditioner_if.slave   pif
);

  localparam int unsigned CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned KEY_W    = 4;
  localparam int unsigned NUM_CH   = 2 * KEY_W + 1;
  localparam int unsigned START_CH = NUM_CH - 1;

  // Channel map: [3:0] player 1, [7:4] player 2, [8] start. All active-low.
  logic [NUM_CH-1:0] raw_n;
  assign raw_n = {pif.btn_start_n, pif.btn_2_n, pif.btn_1_n};

  logic [NUM_CH-1:0] sync1_q, sync1_d;
  logic [NUM_CH-1:0] sync2_q, sync2_d;
  logic [NUM_CH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];

  logic [KEY_W-1:0]  keys_1_q, keys_1_d;
  logic [KEY_W-1:0]  keys_2_q, keys_2_d;
  logic              start_prev_q, start_prev_d;
  logic              start_pulse_q, start_pulse_d;
  logic              pause_q, pause_d;

  logic [KEY_W-1:0]  pressed_1_c;
  logic [KEY_W-1:0]  pressed_2_c;

  // True when exactly one bit of v is set.
  function automatic logic is_one_hot(input logic [KEY_W-1:0] v);
    return (v != '0) && ((v & (v - KEY_W'(1))) == '0);
  endfunction

  // Two-flop synchroniser for every raw button bit.
  always_comb begin
    sync1_d = raw_n;
    sync2_d = sync1_q;
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive
  // cycles of disagreement with the stable state; any agreement restarts.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Key encoding: pass a single held key through, suppress chords.
  always_comb begin
    pressed_1_c = ~stable_q[KEY_W-1:0];
    pressed_2_c = ~stable_q[2*KEY_W-1:KEY_W];
    keys_1_d    = is_one_hot(pressed_1_c) ? pressed_1_c : '0;
    keys_2_d    = is_one_hot(pressed_2_c) ? pressed_2_c : '0;
  end

  // Start edge detect one cycle behind the debouncer so it lines up with keys.
  always_comb begin
    start_prev_d  = stable_q[START_CH];
    start_pulse_d = start_prev_q & ~stable_q[START_CH];
    pause_d       = pause_q ^ start_pulse_d;
  end

  // Synchroniser and debounce state registers.
  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      stable_q <= '1;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Output registers.
  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      keys_1_q      <= '0;
      keys_2_q      <= '0;
      start_prev_q  <= 1'b1;
      start_pulse_q <= 1'b0;
      pause_q       <= 1'b1;
    end else begin
      keys_1_q      <= keys_1_d;
      keys_2_q      <= keys_2_d;
      start_prev_q  <= start_prev_d;
      start_pulse_q <= start_pulse_d;
      pause_q       <= pause_d;
    end
  end

  assign pif.keys_1      = keys_1_q;
  assign pif.keys_2      = keys_2_q;
  assign pif.pause       = pause_q;
  assign pif.start_pulse = start_pulse_q;

endmodule
